// File: rtl/store_drain_unit.sv
// Store drain: pops the head store once it is ready and is the ROB head,
// writes it to dmem and reports completion (or a misalignment error) to the ROB.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   fifo_out        head entry of the store FIFO
//   fifo_empty      store FIFO empty
//   fifo_ren        one-cycle pop of the FIFO head
//   rob_head_*      ROB head valid and index
//   prf_rs*_addr    PRF read addresses, taken straight from the head entry
//   prf_rs*_data    PRF read data, available in the same cycle
//   dmem_addr       word-aligned write address
//   dmem_wmask      byte enables; any bit set means a request is active
//   dmem_wdata      lane-replicated write data
//   dmem_resp       write complete
//   store_done      one-cycle completion pulse
//   store_rob_idx   ROB index of the completed store
//   store_err       with store_done: misaligned or illegal store, no write

package store_drain_pkg;
  localparam int SD_PRF_ADDR_W = 6;
  localparam int SD_ROB_IDX_W  = 5;

  typedef struct packed {
    logic                     ready;
    logic [SD_PRF_ADDR_W-1:0] rs1_paddr;
    logic [SD_PRF_ADDR_W-1:0] rs2_paddr;
    logic [31:0]              imm;
    logic [2:0]               funct3;
    logic [SD_ROB_IDX_W-1:0]  rob_idx;
  } ld_st_data_pkt_t;
endpackage

module store_drain_unit
  import store_drain_pkg::*;
#(
  parameter int PRF_ADDR_W = SD_PRF_ADDR_W,
  parameter int ROB_IDX_W  = SD_ROB_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  ld_st_data_pkt_t       fifo_out,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic                  rob_head_valid,
  input  logic [ROB_IDX_W-1:0]  rob_head_idx,
  output logic [PRF_ADDR_W-1:0] prf_rs1_addr,
  output logic [PRF_ADDR_W-1:0] prf_rs2_addr,
  input  logic [31:0]           prf_rs1_data,
  input  logic [31:0]           prf_rs2_data,
  output logic [31:0]           dmem_addr,
  output logic [3:0]            dmem_wmask,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_resp,
  output logic                  store_done,
  output logic [ROB_IDX_W-1:0]  store_rob_idx,
  output logic                  store_err
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t               state, state_n;
  logic [31:0]          addr_q, addr_n;
  logic [31:0]          wdata_q, wdata_n;
  logic [3:0]           wmask_q, wmask_n;
  logic [ROB_IDX_W-1:0] rob_q, rob_n;
  logic [ROB_IDX_W-1:0] sidx_q, sidx_n;
  logic                 done_q, done_n;
  logic                 err_q, err_n;

  logic [31:0] ea;
  logic [1:0]  off;
  logic [3:0]  mask_c;
  logic [31:0] wdata_c;
  logic        bad;
  logic        go;

  assign prf_rs1_addr = fifo_out.rs1_paddr;
  assign prf_rs2_addr = fifo_out.rs2_paddr;

  assign ea  = prf_rs1_data + fifo_out.imm;
  assign off = ea[1:0];

  // rst gates go so nothing is popped while the unit is held in reset
  assign go = (state == IDLE) & ~rst & ~fifo_empty
            & fifo_out.ready & rob_head_valid
            & (rob_head_idx == fifo_out.rob_idx);

  always_comb begin
    mask_c  = '0;
    wdata_c = '0;
    bad     = 1'b0;
    unique case (1'b1)
      (fifo_out.funct3 == 3'b000): begin
        mask_c  = 4'b0001 << off;
        wdata_c = {4{prf_rs2_data[7:0]}};
      end
      (fifo_out.funct3 == 3'b001): begin
        mask_c  = 4'b0011 << off;
        wdata_c = {2{prf_rs2_data[15:0]}};
        bad     = off[0];
      end
      (fifo_out.funct3 == 3'b010): begin
        mask_c  = 4'b1111;
        wdata_c = prf_rs2_data;
        bad     = |off;
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    wmask_n  = wmask_q;
    wdata_n  = wdata_q;
    rob_n    = rob_q;
    sidx_n   = '0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    fifo_ren = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          fifo_ren = 1'b1;
          rob_n    = fifo_out.rob_idx;
          if (bad) begin
            // rejected store completes without touching dmem
            done_n = 1'b1;
            err_n  = 1'b1;
            sidx_n = fifo_out.rob_idx;
          end else begin
            state_n = ISSUE;
            addr_n  = {ea[31:2], 2'b00};
            wmask_n = mask_c;
            wdata_n = wdata_c;
          end
        end
      end
      ISSUE: begin
        if (dmem_resp) begin
          state_n = IDLE;
          addr_n  = '0;
          wmask_n = '0;
          wdata_n = '0;
          done_n  = 1'b1;
          sidx_n  = rob_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      rob_q   <= '0;
      sidx_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      wmask_q <= wmask_n;
      wdata_q <= wdata_n;
      rob_q   <= rob_n;
      sidx_q  <= sidx_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  assign dmem_addr     = addr_q;
  assign dmem_wmask    = wmask_q;
  assign dmem_wdata    = wdata_q;
  assign store_done    = done_q;
  assign store_rob_idx = sidx_q;
  assign store_err     = err_q;

endmodule

// File: tb/tb_store_drain_unit.sv
// Testbench for store_drain_unit: FIFO/ROB/PRF/dmem environment,
// expected-result queue and an independent monitor.

module tb_store_drain_unit;
  import store_drain_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  ld_st_data_pkt_t fifo_out;
  logic            fifo_empty;
  logic            fifo_ren;
  logic            rob_head_valid;
  logic [4:0]      rob_head_idx;
  logic [5:0]      prf_rs1_addr, prf_rs2_addr;
  logic [31:0]     prf_rs1_data, prf_rs2_data;
  logic [31:0]     dmem_addr;
  logic [3:0]      dmem_wmask;
  logic [31:0]     dmem_wdata;
  logic            dmem_resp;
  logic            store_done;
  logic [4:0]      store_rob_idx;
  logic            store_err;

  store_drain_unit dut (
    .clk(clk), .rst(rst),
    .fifo_out(fifo_out), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
    .rob_head_valid(rob_head_valid), .rob_head_idx(rob_head_idx),
    .prf_rs1_addr(prf_rs1_addr), .prf_rs2_addr(prf_rs2_addr),
    .prf_rs1_data(prf_rs1_data), .prf_rs2_data(prf_rs2_data),
    .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_resp(dmem_resp),
    .store_done(store_done), .store_rob_idx(store_rob_idx),
    .store_err(store_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rob;
    logic        err;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          delay;
  } exp_t;

  exp_t            exq[$];
  exp_t            fexq[$];
  ld_st_data_pkt_t fq[$];
  int              dq[$];
  int              ren_t[$];
  int              done_t[$];
  logic [31:0]     prf [64];

  int   checks = 0;
  int   errors = 0;
  bit   stall_mode = 0;
  bit   force_mis = 0;
  int   ren_cnt = 0;
  int   cyc = 0;
  logic ren_seen = 1'b0;
  logic ren_empty = 1'b0;

  assign prf_rs1_data = prf[prf_rs1_addr];
  assign prf_rs2_data = prf[prf_rs2_addr];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: effective address, byte lane and replication from the ISA rules
  function automatic exp_t model(ld_st_data_pkt_t p, int d);
    exp_t        e;
    logic [31:0] a;
    logic [31:0] s;
    int          o;
    a = prf[p.rs1_paddr] + p.imm;
    s = prf[p.rs2_paddr];
    o = int'(a % 4);
    e.rob = p.rob_idx;
    e.delay = d;
    e.addr = a - 32'(o);
    e.mask = '0;
    e.wdata = '0;
    e.err = 1'b0;
    case (p.funct3)
      3'd0: begin
        e.mask  = 4'(1 << o);
        e.wdata = (s & 32'hff) * 32'h01010101;
      end
      3'd1: begin
        e.err   = (o % 2) != 0;
        e.mask  = 4'(3 << o);
        e.wdata = (s & 32'hffff) * 32'h00010001;
      end
      3'd2: begin
        e.err   = o != 0;
        e.mask  = 4'hf;
        e.wdata = s;
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic push(input logic [5:0] r1, input logic [5:0] r2,
                      input logic [31:0] imm, input logic [2:0] f3,
                      input logic [4:0] rob, input int d);
    ld_st_data_pkt_t p;
    exp_t e;
    p.ready = 1'b1;
    p.rs1_paddr = r1;
    p.rs2_paddr = r2;
    p.imm = imm;
    p.funct3 = f3;
    p.rob_idx = rob;
    e = model(p, d);
    exq.push_back(e);
    fexq.push_back(e);
    fq.push_back(p);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((exq.size() != 0 || fq.size() != 0) && n < bound) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    checks++;
    if (exq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d expected %0d", exq.size(), 0);
      exq.delete();
      fq.delete();
      fexq.delete();
      dq.delete();
    end
  endtask

  always @(posedge clk) begin
    ren_seen  <= fifo_ren;
    ren_empty <= fifo_ren & fifo_empty;
  end

  // Environment: FIFO head, ROB head, dmem responder; all change on negedge
  int rcnt = 0;
  int cur_d = 1;
  always @(negedge clk) begin
    exp_t e;
    if (ren_seen && fq.size() > 0) begin
      void'(fq.pop_front());
      e = fexq.pop_front();
      if (!e.err) dq.push_back(e.delay);
    end
    if (fq.size() > 0) begin
      fifo_empty = 1'b0;
      fifo_out = fq[0];
      if (stall_mode) fifo_out.ready = ($urandom % 4) != 0;
    end else begin
      fifo_empty = 1'b1;
      fifo_out = ld_st_data_pkt_t'({$urandom, $urandom, $urandom});
    end
    rob_head_valid = stall_mode ? (($urandom % 5) != 0) : 1'b1;
    if (fifo_empty)
      rob_head_idx = 5'($urandom);
    else if (force_mis || (stall_mode && ($urandom % 4) == 0))
      rob_head_idx = fifo_out.rob_idx ^ 5'd1;
    else
      rob_head_idx = fifo_out.rob_idx;
    if (dmem_wmask != 0) begin
      if (rcnt == 0) cur_d = (dq.size() > 0) ? dq.pop_front() : 1;
      rcnt++;
      dmem_resp = (rcnt == cur_d);
    end else begin
      rcnt = 0;
      dmem_resp = 1'($urandom % 2);
    end
  end

  // Monitor
  bit          in_req = 0;
  int          held = 0;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_mask;
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (rst) begin
      in_req = 0;
    end else begin
      if (ren_empty) chk("pop_when_empty", 1, 0);
      if (ren_seen) begin
        ren_cnt++;
        ren_t.push_back(cyc - 1);
      end
      if (dmem_wmask != 0) begin
        if (!in_req) begin
          in_req = 1;
          held = 1;
          c_addr = dmem_addr;
          c_mask = dmem_wmask;
          c_wdata = dmem_wdata;
        end else begin
          held++;
          chk("req_stable", {dmem_addr ^ c_addr} | {dmem_wdata ^ c_wdata}
              | 32'(dmem_wmask ^ c_mask), 0);
        end
      end
      if (store_done) begin
        done_t.push_back(cyc);
        if (exq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exq.pop_front();
          chk("rob_idx", 32'(store_rob_idx), 32'(e.rob));
          chk("store_err", 32'(store_err), 32'(e.err));
          chk("req_issued", 32'(in_req), 32'(!e.err));
          if (!e.err && in_req) begin
            chk("dmem_addr", c_addr, e.addr);
            chk("dmem_wmask", 32'(c_mask), 32'(e.mask));
            chk("dmem_wdata", c_wdata, e.wdata);
            chk("held_cycles", held, e.delay);
          end
        end
        in_req = 0;
      end else if (store_err) begin
        chk("err_without_done", 1, 0);
      end
    end
  end

  initial begin
    int n;
    int r;
    rst = 1'b1;
    for (int i = 0; i < 64; i++) prf[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wmask", 32'(dmem_wmask), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_done", 32'(store_done), 0);
    chk("rst_err", 32'(store_err), 0);
    chk("rst_ren", 32'(fifo_ren), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // SW, response after 2 cycles
    prf[1] = 32'h1000;
    prf[2] = 32'hDEADBEEF;
    n = ren_cnt;
    push(6'd1, 6'd2, 32'd4, 3'd2, 5'd3, 2);
    drain(50);
    chk("sw_pop_count", ren_cnt - n, 1);

    // SB at byte 3
    prf[3] = 32'h2000;
    prf[4] = 32'h000000A5;
    push(6'd3, 6'd4, 32'd3, 3'd0, 5'd4, 1);
    drain(50);

    // misaligned SH: pop, error, no request
    prf[5] = 32'h3000;
    n = ren_cnt;
    push(6'd5, 6'd2, 32'd1, 3'd1, 5'd5, 1);
    drain(50);
    chk("sh_err_pop_count", ren_cnt - n, 1);

    // ROB head mismatch blocks the drain
    force_mis = 1;
    n = ren_cnt;
    push(6'd1, 6'd2, 32'd0, 3'd2, 5'd6, 1);
    repeat (10) begin
      @(posedge clk);
      #2;
      chk("mis_no_req", 32'(dmem_wmask), 0);
    end
    chk("mis_no_pop", ren_cnt - n, 0);
    force_mis = 0;
    drain(50);

    // back-to-back SW with zero-wait response
    ren_t.delete();
    done_t.delete();
    push(6'd1, 6'd2, 32'd8, 3'd2, 5'd7, 1);
    push(6'd1, 6'd2, 32'd12, 3'd2, 5'd8, 1);
    drain(50);
    if (ren_t.size() == 2 && done_t.size() == 2) begin
      chk("b2b_first_latency", done_t[0] - ren_t[0], 2);
      chk("b2b_go_in_done", ren_t[1], done_t[0]);
    end else begin
      chk("b2b_count", ren_t.size(), 2);
    end

    // reset during ISSUE drops the request
    push(6'd1, 6'd2, 32'd0, 3'd2, 5'd9, 20);
    n = 0;
    while (dmem_wmask == 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_test_req_seen", 32'(dmem_wmask != 0), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("issue_rst_wmask", 32'(dmem_wmask), 0);
    chk("issue_rst_done", 32'(store_done), 0);
    @(negedge clk);
    rst = 1'b0;
    exq.delete();
    n = ren_cnt;
    repeat (5) @(posedge clk);
    chk("issue_rst_no_pop", ren_cnt - n, 0);

    // randomized traffic with stalls
    stall_mode = 1;
    for (int k = 0; k < 150; k++) begin
      n = 0;
      while (fq.size() > 4 && n < 500) begin
        @(posedge clk);
        n++;
      end
      r = $urandom % 10;
      push(6'($urandom_range(8, 63)), 6'($urandom_range(8, 63)),
           ($urandom % 8 == 0) ? $urandom : 32'($urandom_range(0, 15)),
           (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7)),
           5'($urandom), $urandom_range(1, 4));
    end
    drain(3000);
    stall_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
